mips_boot_loader: RTL and testbench

Byte-stream program loader sitting directly upstream of `MipsProcessor`. It accepts a framed image over a valid/ready byte interface, assembles big-endian 32-bit instruction words and writes them into instruction memory starting at byte address 0. It holds the processor in reset until the full image is written, then releases it. A malformed image leaves the processor held in reset.

---
 rtl/mips_boot_pkg.sv | 23 ++
 rtl/mips_boot_loader_if.sv | 28 ++
 rtl/boot_word_packer.sv | 42 ++++
 rtl/mips_boot_loader.sv | 143 ++++++++++++++
 tb/tb_mips_boot_loader.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the MIPS boot loader: FSM states, header and
// word widths, default image limit and the header length check.
package mips_boot_pkg;

    localparam int HDR_W         = 16;
    localparam int WORD_W        = 32;
    localparam int DEF_MAX_WORDS = 128;

    typedef enum logic [2:0] {
        ST_LEN_HI = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } boot_state_e;

    function automatic logic len_ok(input logic [HDR_W-1:0] n, input int unsigned max_w);
        return (n != {HDR_W{1'b0}}) && ({16'd0, n} <= max_w);
    endfunction

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input and instruction-memory / processor-control outputs of the
// boot loader; slave is the loader side, master is the image source side.
interface mips_boot_loader_if
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W = 9
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_reset, busy, done, error
    );
endinterface

// File: rtl/boot_word_packer.sv
// Assembles four accepted bytes, MSB first, into a 32-bit word and pulses
// word_ready_o alongside the fourth byte.
module boot_word_packer
    import mips_boot_pkg::*;
(
    input  logic              clk_i,
    input  logic              clr_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_ready_o
);
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [1:0]        cnt_q, cnt_d;

    // Shift in the new byte and count bytes within the current word
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (byte_valid_i) begin
            shift_d = {shift_q[WORD_W-9:0], byte_i};
            cnt_d   = cnt_q + 2'd1;
        end else begin
            shift_d = shift_q;
        end
    end

    // Shift register and byte counter state
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            shift_q <= {WORD_W{1'b0}};
            cnt_q   <= 2'd0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign word_o       = shift_q;
    assign word_ready_o = byte_valid_i && (cnt_q == 2'd3);

endmodule

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader writing big-endian words into instruction memory and
// holding the CPU in reset until done. Define BOOT_CHECKSUM_EN for a trailing CSUM byte.
module mips_boot_loader
    import mips_boot_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = DEF_MAX_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    mips_boot_loader_if.slave   bus
);
    localparam int IDX_W = ADDR_W - 2;

    boot_state_e       state_q, state_d;
    logic [HDR_W-1:0]  len_q, len_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [HDR_W-1:0]  len_full_s;
    logic              rx_ready_s;
    logic              accept_s;
    logic              word_ready_s;
    logic [WORD_W-1:0] word_s;
    logic              last_word_s;

    assign rx_ready_s  = state_q inside {ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM};
    assign accept_s    = bus.rx_valid && rx_ready_s;
    assign len_full_s  = {len_q[HDR_W-1:8], bus.rx_data};
    assign last_word_s = ({{(HDR_W-IDX_W){1'b0}}, idx_q} == (len_q - 16'd1));

    boot_word_packer u_packer (
        .clk_i        (clk),
        .clr_i        (reset),
        .byte_valid_i (accept_s && (state_q == ST_DATA)),
        .byte_i       (bus.rx_data),
        .word_o       (word_s),
        .word_ready_o (word_ready_s)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_next_s;

    assign sum_next_s = sum_q + bus.rx_data;

    // Running byte sum over header, payload and CSUM
    always_comb begin
        sum_d = sum_q;
        if (accept_s) begin
            sum_d = sum_next_s;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum accumulator state
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= 8'd0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Next-state, length capture and word index update
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        case (state_q)
            ST_LEN_HI: begin
                if (accept_s) begin
                    len_d   = {bus.rx_data, len_q[7:0]};
                    state_d = ST_LEN_LO;
                end else begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (accept_s) begin
                    len_d   = len_full_s;
                    state_d = len_ok(len_full_s, MAX_WORDS) ? ST_DATA : ST_ERROR;
                end else begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (word_ready_s) begin
                    state_d = ST_WRITE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                idx_d = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (last_word_s) begin
`ifdef BOOT_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            ST_CSUM: begin
                if (accept_s) begin
                    state_d = (sum_next_s == 8'd0) ? ST_DONE : ST_ERROR;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE:  state_d = ST_DONE;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // FSM state, header length and word index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN_HI;
            len_q   <= {HDR_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.rx_ready  = rx_ready_s;
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = {idx_q, 2'b00};
    assign bus.mem_wdata = word_s;
    assign bus.cpu_reset = (state_q != ST_DONE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.error     = (state_q == ST_ERROR);
    assign bus.busy      = state_q inside {ST_LEN_LO, ST_DATA, ST_WRITE, ST_CSUM};

endmodule

// File: tb/tb_mips_boot_loader.sv
// Scoreboard bench for mips_boot_loader: expected writes are queued at stimulus
// time and a negedge monitor checks every mem_we against the queue head.
module tb_mips_boot_loader;
    import mips_boot_pkg::*;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic gaps = 1'b0;
    wr_t  exp_q[$];

`ifdef BOOT_CHECKSUM_EN
    localparam int DONE_LAT = 1;
`else
    localparam int DONE_LAT = 2;
`endif

    always #5 clk = ~clk;

    mips_boot_loader_if #(.ADDR_W(9)) bus ();

    mips_boot_loader #(.ADDR_W(9), .MAX_WORDS(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            check("write_rx_ready_low", {31'd0, bus.rx_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_write: addr %h data %h, no write expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", {23'd0, bus.mem_addr}, {23'd0, e.addr});
                check("write_data", bus.mem_wdata, e.data);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.rx_ready !== 1'b1) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
        end
        @(posedge clk);
        #1 bus.rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("rst_rx_ready",  {31'd0, bus.rx_ready},  32'd1);
        check("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        check("rst_mem_addr",  {23'd0, bus.mem_addr},  32'd0);
        check("rst_mem_wdata", bus.mem_wdata,          32'd0);
        check("rst_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_done",      {31'd0, bus.done},      32'd0);
        check("rst_error",     {31'd0, bus.error},     32'd0);
        reset = 1'b0;
    endtask

    // Sends a full frame; csum_flip corrupts the checksum byte when enabled
    task automatic load(input logic [31:0] words[$], input logic [7:0] csum_flip);
        logic [7:0]  sum;
        logic [15:0] n;
        logic [31:0] w;
        n   = 16'(words.size());
        sum = n[15:8] + n[7:0];
        for (int i = 0; i < words.size(); i++) begin
            exp_q.push_back('{addr: 9'(i * 4), data: words[i]});
        end
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
                send_byte(w[k*8 +: 8]);
                sum = sum + w[k*8 +: 8];
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte((8'd0 - sum) ^ csum_flip);
`else
        if (csum_flip != 8'd0) begin
            $display("note: checksum corruption ignored in this build");
        end
`endif
    endtask

    task automatic wait_end();
        for (int i = 0; i < 200 && !(bus.done === 1'b1 || bus.error === 1'b1); i++) begin
            @(negedge clk);
        end
    endtask

    task automatic bad_len(input logic [15:0] n);
        send_byte(n[15:8]);
        send_byte(n[7:0]);
        @(negedge clk);
        check("badlen_error",     {31'd0, bus.error},     32'd1);
        check("badlen_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        check("badlen_busy",      {31'd0, bus.busy},      32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("badlen_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        end
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        do_reset();

        // Single word, exact DONE latency, then 10 cycles of ignored bytes
        load('{32'h20080005}, 8'h00);
        for (int i = 1; i <= DONE_LAT; i++) begin
            @(negedge clk);
            check("single_done_timing", {31'd0, bus.done}, (i == DONE_LAT) ? 32'd1 : 32'd0);
        end
        check("single_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        check("single_busy",      {31'd0, bus.busy},      32'd0);
        check("single_drained",   exp_q.size(),           32'd0);
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("done_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
            check("done_held",     {31'd0, bus.done},     32'd1);
        end
        bus.rx_valid = 1'b0;

        // Three words with random valid gaps
        do_reset();
        gaps = 1'b1;
        load('{32'h11223344, 32'h55667788, 32'h99AABBCC}, 8'h00);
        gaps = 1'b0;
        wait_end();
        check("n3_done",      {31'd0, bus.done},      32'd1);
        check("n3_cpu_reset", {31'd0, bus.cpu_reset}, 32'd0);
        check("n3_drained",   exp_q.size(),           32'd0);

        // Rejected lengths
        do_reset();
        bad_len(16'h0000);
        do_reset();
        bad_len(16'h0081);

        // Reset after two of four words, then a fresh single-word load
        do_reset();
        exp_q.push_back('{addr: 9'h000, data: 32'hCAFEF00D});
        exp_q.push_back('{addr: 9'h004, data: 32'h0BADBEEF});
        send_byte(8'h00); send_byte(8'h04);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hF0); send_byte(8'h0D);
        send_byte(8'h0B); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        check("mid_two_writes", exp_q.size(), 32'd0);
        do_reset();
        repeat (5) @(negedge clk);
        check("mid_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        check("mid_busy",      {31'd0, bus.busy},      32'd0);
        load('{32'hDEADBEEF}, 8'h00);
        wait_end();
        check("fresh_done",    {31'd0, bus.done}, 32'd1);
        check("fresh_drained", exp_q.size(),      32'd0);

`ifdef BOOT_CHECKSUM_EN
        // Wrong checksum (D3 instead of D2): word still written, CPU held
        do_reset();
        load('{32'h20080005}, 8'h01);
        wait_end();
        check("csum_bad_error",     {31'd0, bus.error},     32'd1);
        check("csum_bad_done",      {31'd0, bus.done},      32'd0);
        check("csum_bad_cpu_reset", {31'd0, bus.cpu_reset}, 32'd1);
        check("csum_bad_written",   exp_q.size(),           32'd0);
`endif

        repeat (3) @(negedge clk);
        check("final_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
